// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//   Bridges the CPU core's single-cycle data-memory request (level MemRead /
//   MemWrite held while stalled) onto a valid/ready data-memory bus with a
//   separate read-response channel. Only one access is in flight at a time.
//   Load data returns to the core through a register. Misaligned accesses,
//   conflicting read+write requests and bus timeouts are reported as a
//   one-cycle pulse on cpu_err.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cpu_addr        byte address from core
//   cpu_wdata       store data from core
//   cpu_mem_read    load request (level)
//   cpu_mem_write   store request (level)
//   cpu_rdata       registered load data to core
//   cpu_stall       core holds its pipeline while high
//   cpu_err         one-cycle pulse, access failed
//   bus_valid       registered request valid
//   bus_we          1 = write, 0 = read
//   bus_addr        word-aligned request address
//   bus_wdata       write data
//   bus_ready       slave accepts the request when bus_valid & bus_ready
//   bus_rvalid      read data valid
//   bus_rdata       read data
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16   // cycles allowed in REQ+RSP, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   input  logic             cpu_mem_read,
   input  logic             cpu_mem_write,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_stall,
   output logic             cpu_err,
   output logic             bus_valid,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_ready,
   input  logic             bus_rvalid,
   input  logic [WIDTH-1:0] bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RSP,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic req;
   logic bad;
   logic cnt_last;

   assign req      = cpu_mem_read | cpu_mem_write;
   assign bad      = (cpu_mem_read & cpu_mem_write) | (cpu_addr[1:0] != 2'b00);
   assign cnt_last = (cnt_q == CNT_LAST);

   // NOTE: every signal written here gets its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (bad) begin
                  state_d = S_ERR;
                  rdata_d = '0;
               end else begin
                  state_d = S_REQ;
                  valid_d = 1'b1;
                  we_d    = cpu_mem_write;
                  addr_d  = {cpu_addr[WIDTH-1:2], 2'b00};
                  wdata_d = cpu_wdata;
                  cnt_d   = '0;
               end
            end
         end

         S_REQ: begin
            // A handshake on the last allowed cycle still wins over the timeout.
            if (bus_ready) begin
               valid_d = 1'b0;
               state_d = we_q ? S_DONE : S_RSP;
               // Saturate so a read that handshook on the last cycle times out
               // in its first RSP cycle unless data is already there.
               if (!cnt_last) cnt_d = cnt_q + 1'b1;
            end else if (cnt_last) begin
               valid_d = 1'b0;
               state_d = S_ERR;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_RSP: begin
            if (bus_rvalid) begin
               rdata_d = bus_rdata;
               state_d = S_DONE;
            end else if (cnt_last) begin
               state_d = S_ERR;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, matching real hardware.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Stall as soon as a request appears in IDLE so the core holds it for the
   // whole access; DONE and ERR release the core for one cycle.
   assign cpu_stall = ((state_q == S_IDLE) & req) | (state_q == S_REQ) | (state_q == S_RSP);
   assign cpu_err   = (state_q == S_ERR);
   assign cpu_rdata = rdata_q;
   assign bus_valid = valid_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
//   Directed bench for dmem_bus_bridge: store, delayed load, misaligned and
//   conflicting requests, REQ timeout, handshake on the last allowed cycle,
//   reset during RSP and back-to-back accesses. Inputs change 1 time unit
//   after the rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_mem_read;
   logic        cpu_mem_write;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_err;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int beats    = 0;

   dmem_bus_bridge #(.WIDTH(32), .TIMEOUT(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_mem_read  (cpu_mem_read),
      .cpu_mem_write (cpu_mem_write),
      .cpu_rdata     (cpu_rdata),
      .cpu_stall     (cpu_stall),
      .cpu_err       (cpu_err),
      .bus_valid     (bus_valid),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_ready     (bus_ready),
      .bus_rvalid    (bus_rvalid),
      .bus_rdata     (bus_rdata)
   );

   always #5 clk = ~clk;

   // Accepted request beats on the bus.
   always @(posedge clk) begin
      if (bus_valid === 1'b1 && bus_ready === 1'b1) beats++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rdata);
      check({tag, "_valid"}, {31'b0, bus_valid}, 32'd0);
      check({tag, "_stall"}, {31'b0, cpu_stall}, 32'd0);
      check({tag, "_err"},   {31'b0, cpu_err},   32'd0);
      check({tag, "_rdata"}, cpu_rdata,          exp_rdata);
   endtask

   initial begin
      rst           = 1'b1;
      cpu_addr      = '0;
      cpu_wdata     = '0;
      cpu_mem_read  = 1'b0;
      cpu_mem_write = 1'b0;
      bus_ready     = 1'b0;
      bus_rvalid    = 1'b0;
      bus_rdata     = '0;

      // ---- reset state ----
      tick();
      tick();
      check_idle_outputs("rst", 32'd0);
      check("rst_we",    {31'b0, bus_we}, 32'd0);
      check("rst_addr",  bus_addr,        32'd0);
      check("rst_wdata", bus_wdata,       32'd0);
      rst = 1'b0;
      tick();

      // ---- 1: store 0x100 <- 0xDEADBEEF, ready at once ----
      cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF; cpu_mem_write = 1'b1; bus_ready = 1'b1;
      #1;
      check("st_idle_stall", {31'b0, cpu_stall}, 32'd1);
      check("st_idle_valid", {31'b0, bus_valid}, 32'd0);
      tick();                                   // REQ
      check("st_req_valid", {31'b0, bus_valid}, 32'd1);
      check("st_req_we",    {31'b0, bus_we},    32'd1);
      check("st_req_addr",  bus_addr,           32'h100);
      check("st_req_wdata", bus_wdata,          32'hDEADBEEF);
      check("st_req_stall", {31'b0, cpu_stall}, 32'd1);
      tick();                                   // DONE
      check_idle_outputs("st_done", 32'd0);
      cpu_mem_write = 1'b0; bus_ready = 1'b0;
      tick();                                   // IDLE
      check("st_beats", beats, 32'd1);

      // ---- 2: load 0x104, ready on 3rd REQ cycle, rvalid on 2nd RSP cycle ----
      cpu_addr = 32'h104; cpu_mem_read = 1'b1;
      tick();                                   // REQ 1
      check("ld_req1_valid", {31'b0, bus_valid}, 32'd1);
      check("ld_req1_we",    {31'b0, bus_we},    32'd0);
      check("ld_req1_addr",  bus_addr,           32'h104);
      tick();                                   // REQ 2
      check("ld_req2_stall", {31'b0, cpu_stall}, 32'd1);
      tick();                                   // REQ 3
      check("ld_req3_valid", {31'b0, bus_valid}, 32'd1);
      bus_ready = 1'b1;
      tick();                                   // RSP 1
      bus_ready = 1'b0;
      check("ld_rsp1_valid", {31'b0, bus_valid}, 32'd0);
      check("ld_rsp1_stall", {31'b0, cpu_stall}, 32'd1);
      tick();                                   // RSP 2
      check("ld_rsp2_rdata", cpu_rdata, 32'd0);
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      tick();                                   // DONE
      bus_rvalid = 1'b0; cpu_mem_read = 1'b0;
      check_idle_outputs("ld_done", 32'h12345678);
      check("ld_beats", beats, 32'd2);
      tick();                                   // IDLE
      // Stray rvalid in IDLE must be ignored.
      bus_rvalid = 1'b1; bus_rdata = 32'h0BAD0BAD;
      tick();
      bus_rvalid = 1'b0;
      check_idle_outputs("stray_rvalid", 32'h12345678);

      // ---- 3: misaligned load 0x102 ----
      cpu_addr = 32'h102; cpu_mem_read = 1'b1;
      #1;
      check("mis_idle_stall", {31'b0, cpu_stall}, 32'd1);
      tick();                                   // ERR
      cpu_mem_read = 1'b0;
      check("mis_err",   {31'b0, cpu_err},   32'd1);
      check("mis_valid", {31'b0, bus_valid}, 32'd0);
      check("mis_stall", {31'b0, cpu_stall}, 32'd0);
      tick();                                   // IDLE
      check_idle_outputs("mis_after", 32'd0);
      check("mis_beats", beats, 32'd2);

      // ---- 4a: read and write together ----
      cpu_addr = 32'h200; cpu_mem_read = 1'b1; cpu_mem_write = 1'b1;
      tick();                                   // ERR
      cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
      check("rw_err",   {31'b0, cpu_err},   32'd1);
      check("rw_valid", {31'b0, bus_valid}, 32'd0);
      tick();
      check_idle_outputs("rw_after", 32'd0);
      check("rw_beats", beats, 32'd2);

      // ---- 4b: bus_ready never comes -> ERR after 16 REQ cycles ----
      cpu_addr = 32'h300; cpu_mem_read = 1'b1;
      tick();                                   // REQ 1
      for (int i = 0; i < 16; i++) begin
         check($sformatf("to_req%0d_valid", i), {31'b0, bus_valid}, 32'd1);
         check($sformatf("to_req%0d_err", i),   {31'b0, cpu_err},   32'd0);
         tick();
      end
      cpu_mem_read = 1'b0;
      check("to_err",   {31'b0, cpu_err},   32'd1);
      check("to_valid", {31'b0, bus_valid}, 32'd0);
      bus_ready = 1'b1;                         // late ready is dropped
      tick();
      bus_ready = 1'b0;
      check_idle_outputs("to_after", 32'd0);
      check("to_beats", beats, 32'd2);

      // ---- 4c: ready on the last allowed REQ cycle wins ----
      cpu_addr = 32'h304; cpu_mem_read = 1'b1;
      tick();                                   // REQ 1 (cnt 0)
      for (int i = 0; i < 15; i++) tick();      // REQ 16 (cnt 15)
      check("edge_valid", {31'b0, bus_valid}, 32'd1);
      bus_ready = 1'b1;
      tick();                                   // RSP
      bus_ready = 1'b0;
      check("edge_rsp_err",   {31'b0, cpu_err},   32'd0);
      check("edge_rsp_stall", {31'b0, cpu_stall}, 32'd1);
      bus_rvalid = 1'b1; bus_rdata = 32'hA5A5A5A5;
      tick();                                   // DONE
      bus_rvalid = 1'b0; cpu_mem_read = 1'b0;
      check_idle_outputs("edge_done", 32'hA5A5A5A5);
      check("edge_beats", beats, 32'd3);
      tick();

      // ---- 5: reset while in RSP ----
      cpu_addr = 32'h400; cpu_mem_read = 1'b1; bus_ready = 1'b1;
      tick();                                   // REQ
      tick();                                   // RSP
      bus_ready = 1'b0;
      check("rr_rsp_stall", {31'b0, cpu_stall}, 32'd1);
      #2;
      rst = 1'b1; cpu_mem_read = 1'b0;
      #1;
      check_idle_outputs("rr_async", 32'd0);
      tick();
      rst = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
      tick();
      bus_rvalid = 1'b0;
      check_idle_outputs("rr_after", 32'd0);
      check("rr_beats", beats, 32'd4);

      // ---- 6: back-to-back store / load / store, ready held high ----
      bus_ready = 1'b1;
      cpu_addr = 32'h500; cpu_wdata = 32'h11111111; cpu_mem_write = 1'b1;
      tick();                                   // REQ
      tick();                                   // DONE, core retires store
      check("b2b_st1_stall", {31'b0, cpu_stall}, 32'd0);
      cpu_mem_write = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 32'h504;
      tick();                                   // IDLE, load pending
      check("b2b_ld_idle_stall", {31'b0, cpu_stall}, 32'd1);
      tick();                                   // REQ
      check("b2b_ld_addr", bus_addr, 32'h504);
      tick();                                   // RSP
      bus_rvalid = 1'b1; bus_rdata = 32'h22222222;
      tick();                                   // DONE, core retires load
      bus_rvalid = 1'b0;
      check("b2b_ld_rdata", cpu_rdata, 32'h22222222);
      cpu_mem_read = 1'b0; cpu_mem_write = 1'b1; cpu_addr = 32'h508; cpu_wdata = 32'h33333333;
      tick();                                   // IDLE
      tick();                                   // REQ
      check("b2b_st2_wdata", bus_wdata, 32'h33333333);
      tick();                                   // DONE
      cpu_mem_write = 1'b0;
      tick();
      tick();
      bus_ready = 1'b0;
      check_idle_outputs("b2b_after", 32'h22222222);
      check("b2b_beats", beats, 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
